// File: rtl/comb_pulse_pkg.sv
// Shared types and defaults for the comb pulse receive-side checker.
package comb_pulse_pkg;

   // Checker FSM states.
   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2,
      LOST     = 2'd3
   } chk_state_e;

   localparam int EXP_PERIOD_DEF = 2;
   localparam int LOCK_N_DEF     = 3;
   localparam int TIMEOUT_DEF    = 4;
   localparam int CNT_W_DEF      = 8;

   // Width needed for the good-interval run counter so it can hold LOCK_N.
   function automatic int good_run_width(input int lock_n);
      int w;
      if (lock_n < 1) begin
         w = 1;
      end else begin
         w = $clog2(lock_n + 1);
      end
      return w;
   endfunction

endpackage

// File: rtl/pulse_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] MAX_C = {W{1'b1}};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear first, otherwise increment until all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_stream_checker.sv
// Receive-side checker for the COMB_PULSE / LEAVING pair: locks onto the
// pulse cadence, flags bad intervals, pulse loss and broken complement.
module pulse_stream_checker
   import comb_pulse_pkg::*;
#(
   parameter int EXP_PERIOD = EXP_PERIOD_DEF,
   parameter int LOCK_N     = LOCK_N_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             pulse_in,
   input  logic             leaving_in,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             about_to_pulse,
   output logic             period_err,
   output logic             timeout_err,
   output logic             pol_err,
   output logic [CNT_W-1:0] pulse_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int               GR_W    = good_run_width(LOCK_N);
   localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] PRE_C   = CNT_W'(EXP_PERIOD - 1);
   localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_MAX = {CNT_W{1'b1}};
   localparam logic [GR_W-1:0]  LOCK_C  = GR_W'(LOCK_N);

   chk_state_e       state_q, state_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             gap_valid_q, gap_valid_d;
   logic [GR_W-1:0]  good_run_q, good_run_d;
   logic             locked_q, locked_d;
   logic             period_err_q, period_err_d;
   logic             timeout_err_q, timeout_err_d;
   logic             pol_err_q, pol_err_d;
   logic             good_iv_s;
   logic [GR_W-1:0]  good_run_inc_s;
   logic             pulse_inc_s;
   logic             err_inc_s;

   // Gap measurement: a pulse restarts the gap, otherwise count up to all-ones.
   always_comb begin
      gap_cnt_d   = gap_cnt_q;
      gap_valid_d = gap_valid_q;
      if (!enable) begin
         gap_cnt_d   = {CNT_W{1'b0}};
         gap_valid_d = 1'b0;
      end else if (pulse_in) begin
         gap_cnt_d   = CNT_W'(1'b1);
         gap_valid_d = 1'b1;
      end else if (gap_cnt_q != GAP_MAX) begin
         gap_cnt_d   = gap_cnt_q + CNT_W'(1'b1);
      end else begin
         gap_cnt_d   = gap_cnt_q;
      end
   end

   // Lock FSM next state, run counter and period/timeout strobes.
   always_comb begin
      state_d        = state_q;
      good_run_d     = good_run_q;
      period_err_d   = 1'b0;
      timeout_err_d  = 1'b0;
      good_iv_s      = gap_valid_q && (gap_cnt_q == EXP_C);
      good_run_inc_s = good_run_q + GR_W'(1'b1);
      if (!enable) begin
         state_d    = DISABLED;
         good_run_d = {GR_W{1'b0}};
      end else begin
         case (state_q)
            DISABLED: begin
               state_d    = ACQUIRE;
               good_run_d = {GR_W{1'b0}};
            end
            ACQUIRE: begin
               if (pulse_in && good_iv_s) begin
                  if (good_run_inc_s == LOCK_C) begin
                     state_d    = LOCKED;
                     good_run_d = {GR_W{1'b0}};
                  end else begin
                     good_run_d = good_run_inc_s;
                  end
               end else if (pulse_in) begin
                  good_run_d = {GR_W{1'b0}};
               end else begin
                  good_run_d = good_run_q;
               end
            end
            LOCKED: begin
               if (pulse_in && !good_iv_s) begin
                  period_err_d = 1'b1;
                  state_d      = ACQUIRE;
                  good_run_d   = {GR_W{1'b0}};
               end else if (!pulse_in && (gap_cnt_q == TO_C)) begin
                  timeout_err_d = 1'b1;
                  state_d       = LOST;
               end else begin
                  state_d = LOCKED;
               end
            end
            LOST: begin
               if (pulse_in) begin
                  state_d    = ACQUIRE;
                  good_run_d = {GR_W{1'b0}};
               end else begin
                  state_d = LOST;
               end
            end
            default: begin
               state_d    = DISABLED;
               good_run_d = {GR_W{1'b0}};
            end
         endcase
      end
      pol_err_d   = enable && (state_q != DISABLED) && (leaving_in == pulse_in);
      locked_d    = (state_d == LOCKED);
      err_inc_s   = period_err_d || timeout_err_d || pol_err_d;
      pulse_inc_s = enable && pulse_in;
   end

   // State, gap tracking and registered status/strobe outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= DISABLED;
         gap_cnt_q     <= {CNT_W{1'b0}};
         gap_valid_q   <= 1'b0;
         good_run_q    <= {GR_W{1'b0}};
         locked_q      <= 1'b0;
         period_err_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         pol_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         gap_cnt_q     <= gap_cnt_d;
         gap_valid_q   <= gap_valid_d;
         good_run_q    <= good_run_d;
         locked_q      <= locked_d;
         period_err_q  <= period_err_d;
         timeout_err_q <= timeout_err_d;
         pol_err_q     <= pol_err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_pulse_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i (pulse_inc_s),
      .clr_i (clr_cnt),
      .cnt_o (pulse_count)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i (err_inc_s),
      .clr_i (clr_cnt),
      .cnt_o (err_count)
   );

   assign locked         = locked_q;
   assign about_to_pulse = locked_q && (gap_cnt_q == PRE_C);
   assign period_err     = period_err_q;
   assign timeout_err    = timeout_err_q;
   assign pol_err        = pol_err_q;

endmodule

// File: tb/tb_pulse_stream_checker.sv
// Directed bench for pulse_stream_checker with a cycle-stamped scoreboard.
module tb_pulse_stream_checker;

   logic       clk;
   logic       rstn;
   logic       enable;
   logic       pulse_in;
   logic       leaving_in;
   logic       clr_cnt;
   logic       locked;
   logic       about_to_pulse;
   logic       period_err;
   logic       timeout_err;
   logic       pol_err;
   logic [7:0] pulse_count;
   logic [7:0] err_count;

   typedef struct {
      int          cyc;
      int          fld;
      logic [31:0] val;
   } lvl_t;

   typedef struct {
      int          cyc;
      logic [2:0]  bits;   // {period, timeout, pol}
      logic [31:0] ecnt;
   } stb_t;

   lvl_t lq[$];
   stb_t sq[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   pulse_stream_checker #(
      .EXP_PERIOD (2),
      .LOCK_N     (3),
      .TIMEOUT    (4),
      .CNT_W      (8)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .enable         (enable),
      .pulse_in       (pulse_in),
      .leaving_in     (leaving_in),
      .clr_cnt        (clr_cnt),
      .locked         (locked),
      .about_to_pulse (about_to_pulse),
      .period_err     (period_err),
      .timeout_err    (timeout_err),
      .pol_err        (pol_err),
      .pulse_count    (pulse_count),
      .err_count      (err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] field_val(input int f);
      logic [31:0] v;
      case (f)
         0:       v = {31'd0, locked};
         1:       v = {31'd0, about_to_pulse};
         2:       v = {31'd0, period_err};
         3:       v = {31'd0, timeout_err};
         4:       v = {31'd0, pol_err};
         5:       v = {24'd0, pulse_count};
         6:       v = {24'd0, err_count};
         default: v = 32'hDEAD_BEEF;
      endcase
      return v;
   endfunction

   function automatic string field_name(input int f);
      string s;
      case (f)
         0:       s = "locked";
         1:       s = "about_to_pulse";
         2:       s = "period_err";
         3:       s = "timeout_err";
         4:       s = "pol_err";
         5:       s = "pulse_count";
         6:       s = "err_count";
         default: s = "unknown";
      endcase
      return s;
   endfunction

   // Monitor: level expectations due this cycle, and strobe events as they appear.
   initial begin
      logic [31:0] act;
      stb_t        e;
      forever begin
         @(negedge clk);
         for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].cyc == cyc) begin
               act = field_val(lq[i].fld);
               checks++;
               if (act !== lq[i].val) begin
                  errors++;
                  $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                           field_name(lq[i].fld), cyc, act, lq[i].val);
               end
               lq.delete(i);
            end
         end
         if (period_err || timeout_err || pol_err) begin
            checks++;
            if (sq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe cyc=%0d got={p,t,pol}=%b expected none",
                        cyc, {period_err, timeout_err, pol_err});
            end else begin
               e = sq.pop_front();
               if (e.cyc != cyc || e.bits !== {period_err, timeout_err, pol_err}
                   || e.ecnt !== {24'd0, err_count}) begin
                  errors++;
                  $display("FAIL strobe cyc=%0d got={p,t,pol}=%b err_count=%0d expected cyc=%0d {p,t,pol}=%b err_count=%0d",
                           cyc, {period_err, timeout_err, pol_err}, err_count,
                           e.cyc, e.bits, e.ecnt);
               end
            end
         end
      end
   end

   task automatic expect_lvl(input int c, input int f, input logic [31:0] v);
      lvl_t x;
      x.cyc = c;
      x.fld = f;
      x.val = v;
      lq.push_back(x);
   endtask

   task automatic expect_stb(input int c, input logic [2:0] b, input logic [31:0] ec);
      stb_t x;
      x.cyc  = c;
      x.bits = b;
      x.ecnt = ec;
      sq.push_back(x);
   endtask

   task automatic expect_zero(input int c);
      for (int f = 0; f < 7; f++) expect_lvl(c, f, 32'd0);
   endtask

   task automatic drive(input logic p, input logic l, input logic en, input logic c);
      pulse_in   = p;
      leaving_in = l;
      enable     = en;
      clr_cnt    = c;
      @(posedge clk);
      #1;
   endtask

   task automatic train(input int n);
      for (int k = 0; k < n; k++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0);
         drive(1'b0, 1'b1, 1'b1, 1'b0);
      end
   endtask

   // Stimulus: directed scenarios; expectations pushed ahead of time.
   initial begin
      int t0, l, p, q, r, s, u, v;
      rstn = 1'b0; enable = 1'b0; pulse_in = 1'b0; leaving_in = 1'b1; clr_cnt = 1'b0;
      @(posedge clk);
      #1;
      expect_zero(cyc);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      rstn = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b0);

      // Ideal generator, 10 pulses.
      t0 = cyc;
      expect_lvl(t0 + 1, 5, 32'd1);
      expect_lvl(t0 + 5, 1, 32'd0);
      expect_lvl(t0 + 6, 0, 32'd0);
      expect_lvl(t0 + 7, 0, 32'd1);
      expect_lvl(t0 + 7, 1, 32'd1);
      expect_lvl(t0 + 8, 1, 32'd0);
      expect_lvl(t0 + 9, 1, 32'd1);
      expect_lvl(t0 + 19, 5, 32'd10);
      expect_lvl(t0 + 19, 6, 32'd0);
      train(10);

      // Pulses stop after the pulse at l.
      l = t0 + 18;
      expect_lvl(l + 4, 0, 32'd1);
      expect_lvl(l + 5, 0, 32'd0);
      expect_stb(l + 5, 3'b010, 32'd1);
      for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 1'b1, 1'b0);
      p = cyc;
      expect_lvl(p + 6, 0, 32'd0);
      expect_lvl(p + 7, 0, 32'd1);
      expect_lvl(p + 7, 5, 32'd14);
      train(4);

      // One interval of 3 cycles while locked.
      q = cyc;
      expect_lvl(q + 3, 0, 32'd1);
      expect_lvl(q + 4, 0, 32'd0);
      expect_stb(q + 4, 3'b100, 32'd2);
      expect_lvl(q + 9, 0, 32'd0);
      expect_lvl(q + 10, 0, 32'd1);
      expect_lvl(q + 12, 5, 32'd20);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      train(4);

      // Broken complement on a good pulse, then on a late pulse.
      r = cyc;
      expect_stb(r + 1, 3'b001, 32'd3);
      expect_lvl(r + 1, 0, 32'd1);
      expect_stb(r + 4, 3'b101, 32'd4);
      expect_lvl(r + 4, 0, 32'd0);
      expect_lvl(r + 4, 6, 32'd4);
      expect_lvl(r + 10, 0, 32'd1);
      expect_lvl(r + 12, 5, 32'd26);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      train(4);

      // Saturation of pulse_count, then clear on a pulse cycle.
      s = cyc;
      expect_lvl(s + 456, 5, 32'd254);
      expect_lvl(s + 457, 5, 32'd255);
      expect_lvl(s + 600, 5, 32'd255);
      expect_lvl(s + 600, 0, 32'd1);
      train(300);
      u = cyc;
      expect_lvl(u + 1, 5, 32'd0);
      expect_lvl(u + 1, 6, 32'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0);

      // Disable while locked, then asynchronous reset mid-gap.
      v = cyc;
      expect_lvl(v + 1, 5, 32'd1);
      expect_lvl(v + 2, 0, 32'd1);
      expect_lvl(v + 3, 0, 32'd0);
      expect_lvl(v + 6, 5, 32'd1);
      expect_lvl(v + 6, 6, 32'd0);
      expect_lvl(v + 8, 5, 32'd2);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      expect_zero(cyc);
      #2;
      rstn = 1'b0;
      pulse_in = 1'b1;
      leaving_in = 1'b1;
      @(posedge clk);
      #1;
      expect_zero(cyc);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      t0 = cyc;
      expect_lvl(t0 + 6, 0, 32'd0);
      expect_lvl(t0 + 7, 0, 32'd1);
      expect_lvl(t0 + 7, 1, 32'd1);
      expect_lvl(t0 + 7, 5, 32'd4);
      train(4);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b1, 1'b0);

      checks++;
      if (lq.size() != 0) begin
         errors++;
         $display("FAIL pending_levels got=%0d expected=0", lq.size());
      end
      checks++;
      if (sq.size() != 0) begin
         errors++;
         $display("FAIL missing_strobes got=%0d expected=0", sq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
